dcache_2way_wb: RTL

//  Two-way set-associative, write-back, write-allocate L1 data cache between the
//  CPU MEM stage and the 256-bit data memory. Next generation of the direct-mapped

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_way_store.sv | 58 +++++
 rtl/dcache_2way_wb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared constants for the two-way write-back data cache: FSM encoding,
// default geometry and the per-line tag entry.
package dcache_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_LINE_BYTES = 32;
  localparam int DEF_SETS       = 16;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_LINE_W     = 8 * DEF_LINE_BYTES;
  localparam int DEF_OFF_W      = $clog2(DEF_LINE_BYTES);
  localparam int DEF_IDX_W      = $clog2(DEF_SETS);
  localparam int DEF_TAG_W      = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

  // Tag field sized for the widest possible tag; ways use the low TAG_W bits.
  localparam int MAX_TAG_W = 32;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_MISS        = 3'd1;
  localparam logic [2:0] S_WRITEBACK   = 3'd2;
  localparam logic [2:0] S_REFILL      = 3'd3;
  localparam logic [2:0] S_REFILL_DONE = 3'd4;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/dcache_way_store.sv
// One cache way: valid/dirty bits, tag array and line array with a
// combinational lookup port, a CPU word-merge port and a refill line port.
module dcache_way_store
  import dcache_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int WSEL_W = $clog2(DEF_LINE_W / 32)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output tag_entry_t        rd_entry,
  output logic [LINE_W-1:0] rd_line,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  input  logic              line_we,
  input  logic [LINE_W-1:0] line_data,
  input  logic [TAG_W-1:0]  line_tag
);

  logic [SETS-1:0]   valid_reg;
  logic [SETS-1:0]   dirty_reg;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (line_we) begin
      valid_reg[wr_idx] <= 1'b1;
      dirty_reg[wr_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_reg[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[wr_idx]  <= line_tag;
      data_mem[wr_idx] <= line_data;
    end else if (word_we) begin
      data_mem[wr_idx][word_sel*32 +: 32] <= word_data;
    end
  end

  assign rd_entry = '{valid: valid_reg[rd_idx],
                      dirty: dirty_reg[rd_idx],
                      tag:   MAX_TAG_W'(tag_mem[rd_idx])};
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_2way_wb.sv
// Two-way set-associative write-back, write-allocate L1 data cache with
// per-set LRU bit, one outstanding memory transaction and hit/miss counters.
module dcache_2way_wb
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int SETS       = DEF_SETS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LINE_W     = 8 * LINE_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [CNT_W-1:0]  stat_hit_o,
  output logic [CNT_W-1:0]  stat_miss_o
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  logic [2:0]        state_reg;
  logic [TAG_W-1:0]  miss_tag_reg;
  logic [IDX_W-1:0]  miss_set_reg;
  logic              victim_reg;
  logic [SETS-1:0]   lru_reg;
  logic              mem_enable_reg;
  logic              mem_write_reg;
  logic [CNT_W-1:0]  hit_cnt_reg;
  logic [CNT_W-1:0]  miss_cnt_reg;

  logic              req;
  logic              idle;
  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_set;
  logic [WSEL_W-1:0] cpu_word;
  logic [IDX_W-1:0]  rd_idx;
  tag_entry_t        entry [2];
  logic [LINE_W-1:0] line  [2];
  logic [1:0]        way_hit;
  logic              hit;
  logic              hit_way;
  logic [LINE_W-1:0] hit_line;
  logic              victim_sel;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic              unused_bits;

  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign idle     = (state_reg == S_IDLE);
  assign cpu_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_set  = p1_addr_i[OFF_W +: IDX_W];
  assign cpu_word = p1_addr_i[2 +: WSEL_W];
  // Outside IDLE the arrays look at the latched miss set, not the live CPU address.
  assign rd_idx   = idle ? cpu_set : miss_set_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      dcache_way_store #(
        .SETS   (SETS),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W),
        .WSEL_W (WSEL_W)
      ) u_way (
        .clk       (clk_i),
        .rst       (rst_i),
        .rd_idx    (rd_idx),
        .rd_entry  (entry[gi]),
        .rd_line   (line[gi]),
        .wr_idx    (rd_idx),
        .word_we   (p1_MemWrite_i & way_hit[gi]),
        .word_sel  (cpu_word),
        .word_data (p1_data_i),
        .line_we   ((state_reg == S_REFILL) & mem_ack_i & (victim_reg == 1'(gi))),
        .line_data (mem_data_i),
        .line_tag  (miss_tag_reg)
      );
      assign way_hit[gi] = idle & entry[gi].valid & (entry[gi].tag[TAG_W-1:0] == cpu_tag);
    end
  endgenerate

  assign hit        = |way_hit;
  assign hit_way    = way_hit[1];
  assign hit_line   = hit_way ? line[1] : line[0];
  assign p1_data_o  = hit_line[cpu_word*32 +: 32];
  assign p1_stall_o = req & ~hit;

  assign victim_sel   = !entry[0].valid ? 1'b0 :
                        !entry[1].valid ? 1'b1 : lru_reg[cpu_set];
  assign victim_dirty = entry[victim_reg].valid & entry[victim_reg].dirty;
  assign victim_tag   = entry[victim_reg].tag[TAG_W-1:0];

  assign mem_data_o   = line[victim_reg];
  assign mem_addr_o   = (state_reg == S_WRITEBACK) ?
                        {victim_tag, miss_set_reg, {OFF_W{1'b0}}} :
                        {miss_tag_reg, miss_set_reg, {OFF_W{1'b0}}};
  assign mem_enable_o = mem_enable_reg;
  assign mem_write_o  = mem_write_reg;
  assign stat_hit_o   = hit_cnt_reg;
  assign stat_miss_o  = miss_cnt_reg;

  assign unused_bits = ^{p1_addr_i[1:0], entry[0].tag[MAX_TAG_W-1:TAG_W],
                         entry[1].tag[MAX_TAG_W-1:TAG_W]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= S_IDLE;
      miss_tag_reg   <= '0;
      miss_set_reg   <= '0;
      victim_reg     <= 1'b0;
      lru_reg        <= '0;
      mem_enable_reg <= 1'b0;
      mem_write_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req && hit) begin
            // LRU bit names the way to evict next: the one not just used.
            lru_reg[cpu_set] <= ~hit_way;
          end else if (req) begin
            miss_tag_reg <= cpu_tag;
            miss_set_reg <= cpu_set;
            victim_reg   <= victim_sel;
            state_reg    <= S_MISS;
          end
        end
        S_MISS: begin
          mem_enable_reg <= 1'b1;
          mem_write_reg  <= victim_dirty;
          state_reg      <= victim_dirty ? S_WRITEBACK : S_REFILL;
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_reg <= 1'b0;
            state_reg     <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            mem_enable_reg <= 1'b0;
            state_reg      <= S_REFILL_DONE;
          end
        end
        S_REFILL_DONE: state_reg <= S_IDLE;
        default: begin
          mem_enable_reg <= 1'b0;
          mem_write_reg  <= 1'b0;
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (idle && req && hit && !(&hit_cnt_reg))
        hit_cnt_reg <= hit_cnt_reg + 1'b1;
      if (idle && req && !hit && !(&miss_cnt_reg))
        miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

endmodule
